retire_trace_fifo: RTL

- Downstream consumer of the dual-issue core's retirement outputs (update/pc/instr/reg/mem lanes).
- Captures up to two retired-instruction records per cycle, in program order, into a circular buffer.
- Drains the buffer as a single-record-per-cycle valid/ready stream toward the trace logger or table writer.
- Provides sequence numbering, drop accounting and an almost-full stall request so commit traces are never silently reordered or corrupted.

---
 rtl/retire_trace_fifo.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/retire_trace_fifo.sv
// retire_trace_fifo: captures up to two retired-instruction records per cycle,
// in program order, into a circular buffer. It drains them as a one-record-per-cycle
// valid/ready stream, and adds sequence numbers, drop accounting and an almost-full stall.
module retire_trace_fifo #(
  parameter int XLEN            = 32,
  parameter int Depth           = 16,
  parameter int AlmostFullSlack = 2
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clear_i,
  input  logic [1:0]              update_i,
  input  logic [2*XLEN-1:0]       pc_i,
  input  logic [2*XLEN-1:0]       instr_i,
  input  logic [9:0]              reg_addr_i,
  input  logic [2*XLEN-1:0]       reg_data_i,
  input  logic [2*XLEN-1:0]       mem_addr_i,
  input  logic [2*XLEN-1:0]       mem_data_i,
  input  logic [1:0]              mem_wrt_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [XLEN-1:0]         pc_o,
  output logic [XLEN-1:0]         instr_o,
  output logic [XLEN-1:0]         reg_data_o,
  output logic [XLEN-1:0]         mem_addr_o,
  output logic [XLEN-1:0]         mem_data_o,
  output logic [4:0]              reg_addr_o,
  output logic                    mem_wrt_o,
  output logic                    lane_o,
  output logic [31:0]             seq_o,
  output logic [$clog2(Depth):0]  count_o,
  output logic                    stall_req_o,
  output logic                    overflow_o,
  output logic [15:0]             drop_cnt_o
);

  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] reg_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic [4:0]      reg_addr;
    logic            mem_wrt;
    logic            lane;
    logic [31:0]     seq;
  } rec_t;

  rec_t buf_mem [Depth];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_nxt;
  logic [CW-1:0] count_q, count_d, space, free_d;
  logic [31:0]   seq_q, seq_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [16:0]   drop_sum;
  logic          valid_q, valid_d, stall_q, stall_d, overflow_q, overflow_d;
  logic          pop;
  logic [1:0]    n, accepted, dropped;
  rec_t          lane_rec [2];
  rec_t          rec_first, rec_second, head;

  assign wr_ptr_nxt = wr_ptr_q + PW'(1);

  // Unpack both lanes and order them: the oldest set lane goes first and gets seq_q.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      lane_rec[l].pc       = pc_i[l*XLEN +: XLEN];
      lane_rec[l].instr    = instr_i[l*XLEN +: XLEN];
      lane_rec[l].reg_data = reg_data_i[l*XLEN +: XLEN];
      lane_rec[l].mem_addr = mem_addr_i[l*XLEN +: XLEN];
      lane_rec[l].mem_data = mem_data_i[l*XLEN +: XLEN];
      lane_rec[l].reg_addr = reg_addr_i[l*5 +: 5];
      lane_rec[l].mem_wrt  = mem_wrt_i[l];
      lane_rec[l].lane     = (l == 1);
      lane_rec[l].seq      = seq_q;
    end
    rec_first      = (update_i == 2'b10) ? lane_rec[1] : lane_rec[0];
    rec_first.seq  = seq_q;
    rec_second     = lane_rec[1];
    rec_second.seq = seq_q + 32'd1;
  end

  // Work out how many records fit this cycle, then compute every next-state value.
  always_comb begin
    pop      = valid_q & ready_i;
    n        = {1'b0, update_i[0]} + {1'b0, update_i[1]};
    space    = CW'(Depth) - count_q + CW'(pop);
    accepted = (space >= CW'(n)) ? n : space[1:0];
    dropped  = n - accepted;
    drop_sum = {1'b0, drop_cnt_q} + 17'(dropped);

    wr_ptr_d   = wr_ptr_q + PW'(accepted);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(accepted) - CW'(pop);
    seq_d      = seq_q + 32'(n);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    overflow_d = overflow_q | (dropped != 2'd0);
    free_d     = CW'(Depth) - count_d;
    stall_d    = (free_d <= CW'(AlmostFullSlack));
    valid_d    = (count_d != '0);

    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      seq_d      = '0;
      drop_cnt_d = '0;
      overflow_d = 1'b0;
      stall_d    = 1'b0;
      valid_d    = 1'b0;
    end
  end

  // Control state: pointers, occupancy, counters and registered status outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      stall_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      stall_q    <= stall_d;
      valid_q    <= valid_d;
    end
  end

  // Record storage: only accepted records are written, so unread entries are never overwritten.
  always_ff @(posedge clk_i) begin
    if (rstn_i && !clear_i) begin
      if (accepted != 2'd0) buf_mem[wr_ptr_q] <= rec_first;
      if (accepted == 2'd2) buf_mem[wr_ptr_nxt] <= rec_second;
    end
  end

  // Show-ahead head record, forced to zero while the buffer is empty.
  always_comb begin
    head = '0;
    if (valid_q) head = buf_mem[rd_ptr_q];
  end

  assign valid_o     = valid_q;
  assign pc_o        = head.pc;
  assign instr_o     = head.instr;
  assign reg_data_o  = head.reg_data;
  assign mem_addr_o  = head.mem_addr;
  assign mem_data_o  = head.mem_data;
  assign reg_addr_o  = head.reg_addr;
  assign mem_wrt_o   = head.mem_wrt;
  assign lane_o      = head.lane;
  assign seq_o       = head.seq;
  assign count_o     = count_q;
  assign stall_req_o = stall_q;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule
